alu_cmd_sequencer: RTL and testbench

Upstream command stage for the ALU_Project datapath.
- Buffers ALU commands {op, a, b} from a valid/ready producer in a small FIFO.
- Issues one command at a time to the ALU with a single-cycle start pulse, then waits for done and captures the 16-bit result.
- Presents the result downstream with a valid/ready handshake, a sequence tag and a timeout error flag.

---
 rtl/alu_cmd_sequencer.sv | 109 ++++++++++
 tb/tb_alu_cmd_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: queues ALU commands, issues them one at a time and returns tagged results.
module alu_cmd_sequencer #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    output logic        alu_start,
    output logic [2:0]  alu_op,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    input  logic        alu_done,
    input  logic [15:0] alu_result,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_data,
    output logic [3:0]  res_tag,
    output logic        res_err,
    output logic        busy,
    output logic [7:0]  err_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    logic [18:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic [1:0]    state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [2:0]    op_q;
    logic [7:0]    a_q, b_q, err_cnt_q;
    logic [15:0]   res_data_q;
    logic [3:0]    tag_q;
    logic          res_err_q;
    logic          empty, push, pop, timeout, hs, wait_done, wait_to;

    assign empty     = count_q == '0;
    assign cmd_ready = count_q != (AW+1)'(DEPTH);
    assign push      = cmd_valid && cmd_ready;
    assign pop       = state_q == S_IDLE && !empty;
    assign timeout   = tmo_q == TW'(TIMEOUT - 1);
    assign hs        = state_q == S_OUT && res_ready;
    assign wait_done = state_q == S_WAIT && alu_done;
    assign wait_to   = state_q == S_WAIT && !alu_done && timeout;
    assign count_d   = count_q + (AW+1)'(push) - (AW+1)'(pop);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = empty ? S_IDLE : S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  state_d = (alu_done || timeout) ? S_OUT : S_WAIT;
            default: state_d = res_ready ? S_IDLE : S_OUT;
        endcase
        tmo_d = state_q == S_ISSUE ? '0 : state_q == S_WAIT ? tmo_q + 1'b1 : tmo_q;
    end

    // Storage needs no reset: emptiness is carried entirely by the count.
    always_ff @(posedge clk)
        if (push) mem_q[wr_ptr_q] <= {cmd_op, cmd_a, cmd_b};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= S_IDLE;
            tmo_q      <= '0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            res_data_q <= '0;
            res_err_q  <= 1'b0;
            tag_q      <= '0;
            err_cnt_q  <= '0;
        end else begin
            wr_ptr_q   <= push ? wr_ptr_q + 1'b1 : wr_ptr_q;
            rd_ptr_q   <= pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
            count_q    <= count_d;
            state_q    <= state_d;
            tmo_q      <= tmo_d;
            {op_q, a_q, b_q} <= pop ? mem_q[rd_ptr_q] : {op_q, a_q, b_q};
            res_data_q <= wait_done ? alu_result : wait_to ? 16'h0000 : res_data_q;
            res_err_q  <= wait_done ? 1'b0 : wait_to ? 1'b1 : res_err_q;
            tag_q      <= hs ? tag_q + 1'b1 : tag_q;
            err_cnt_q  <= (wait_to && err_cnt_q != 8'hff) ? err_cnt_q + 1'b1 : err_cnt_q;
        end
    end

    assign alu_start = state_q == S_ISSUE;
    assign alu_op    = op_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign res_valid = state_q == S_OUT;
    assign res_data  = res_data_q;
    assign res_tag   = tag_q;
    assign res_err   = res_err_q;
    assign busy      = state_q != S_IDLE || !empty;
    assign err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: random traffic against a queue-based reference of the command sequencer.
module tb_alu_cmd_sequencer;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;
    localparam int NEVER   = 1000;

    logic        clk = 1'b0, reset_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready;
    logic [2:0]  cmd_op = '0;
    logic [7:0]  cmd_a = '0, cmd_b = '0;
    logic        alu_start, alu_done = 1'b0;
    logic [2:0]  alu_op;
    logic [7:0]  alu_a, alu_b, err_cnt;
    logic [15:0] alu_result = '0, res_data;
    logic        res_valid, res_ready = 1'b0, res_err, busy;
    logic [3:0]  res_tag;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_done(alu_done), .alu_result(alu_result),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_tag(res_tag),
        .res_err(res_err), .busy(busy), .err_cnt(err_cnt)
    );

    typedef struct {logic [2:0] op; logic [7:0] a; logic [7:0] b; int lat;} cmd_t;
    typedef struct {logic [15:0] data; logic err;} res_t;

    cmd_t src_q[$], fifo_q[$], cur, drv;
    res_t exp_q[$];
    int   n_cmp = 0, n_bad = 0;
    int   rem = -1, ready_pct = 100, exp_tag = 0, errs = 0;
    bit   inflight = 0, hs_pend = 0, push_pend = 0, saw_full = 0;

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] alu_ref(cmd_t c);
        case (c.op)
            3'd0: return 16'(c.a) + 16'(c.b);
            3'd1: return 16'(c.a) - 16'(c.b);
            3'd2: return 16'(c.a) * 16'(c.b);
            3'd3: return 16'(c.a & c.b);
            3'd4: return 16'(c.a | c.b);
            3'd5: return 16'(c.a ^ c.b);
            3'd6: return {c.a, c.b};
            default: return ~{c.a, c.b};
        endcase
    endfunction

    function automatic cmd_t mk(logic [2:0] op, logic [7:0] a, logic [7:0] b, int lat);
        cmd_t c;
        c.op = op; c.a = a; c.b = b; c.lat = lat;
        return c;
    endfunction

    function automatic int rnd_lat();
        int r = $urandom_range(99);
        return r < 75 ? int'($urandom_range(4, 1)) : r < 82 ? TIMEOUT : r < 89 ? TIMEOUT + 1 :
               r < 94 ? NEVER : int'($urandom_range(10, 5));
    endfunction

    task automatic step();
        int ec;
        @(posedge clk); #1;
        if (hs_pend) begin
            errs = errs + int'(exp_q[0].err);
            void'(exp_q.pop_front());
            exp_tag = (exp_tag + 1) % 16;
            inflight = 0;
            hs_pend = 0;
        end
        if (push_pend) begin
            fifo_q.push_back(drv);
            push_pend = 0;
            cmd_valid = 1'b0;
        end
        if (rem > 0) rem--;
        if (alu_start) begin
            chk("start_while_busy", 32'(inflight), 0);
            chk("start_fifo_nonempty", 32'(fifo_q.size() != 0), 1);
            if (fifo_q.size() != 0) begin
                res_t r;
                cur = fifo_q.pop_front();
                chk("issue_op", 32'(alu_op), 32'(cur.op));
                chk("issue_a", 32'(alu_a), 32'(cur.a));
                chk("issue_b", 32'(alu_b), 32'(cur.b));
                r.err = cur.lat > TIMEOUT;
                r.data = r.err ? 16'h0000 : alu_ref(cur);
                exp_q.push_back(r);
                rem = cur.lat;
                inflight = 1;
            end
        end else if (inflight) begin
            chk("hold_op", 32'(alu_op), 32'(cur.op));
            chk("hold_a", 32'(alu_a), 32'(cur.a));
            chk("hold_b", 32'(alu_b), 32'(cur.b));
        end
        if (!cmd_ready) saw_full = 1;
        chk("cmd_ready", 32'(cmd_ready), 32'(fifo_q.size() < DEPTH));
        chk("busy", 32'(busy), 32'(inflight || fifo_q.size() != 0));
        chk("res_tag", 32'(res_tag), 32'(exp_tag));
        ec = errs + int'(res_valid && exp_q.size() != 0 && exp_q[0].err);
        chk("err_cnt", 32'(err_cnt), 32'(ec > 255 ? 255 : ec));
        if (res_valid) begin
            chk("res_expected", 32'(exp_q.size() != 0 && inflight), 1);
            if (exp_q.size() != 0) begin
                chk("res_data", 32'(res_data), 32'(exp_q[0].data));
                chk("res_err", 32'(res_err), 32'(exp_q[0].err));
            end
            if (rem > 2) rem = -1;
        end
        alu_done = rem == 0 || (rem < 0 && $urandom_range(3) == 0);
        alu_result = rem == 0 ? alu_ref(cur) : 16'($urandom);
        if (rem == 0) rem = -1;
        res_ready = $urandom_range(99) < ready_pct;
        hs_pend = res_valid && res_ready;
        if (!cmd_valid && src_q.size() != 0) begin
            drv = src_q.pop_front();
            {cmd_valid, cmd_op, cmd_a, cmd_b} = {1'b1, drv.op, drv.a, drv.b};
        end
        push_pend = cmd_valid && cmd_ready;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; cmd_valid = 1'b0; res_ready = 1'b0; alu_done = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        src_q.delete(); fifo_q.delete(); exp_q.delete();
        {inflight, hs_pend, push_pend} = '0;
        exp_tag = 0; errs = 0; rem = -1;
        chk("rst_alu_start", 32'(alu_start), 0);
        chk("rst_alu_op", 32'(alu_op), 0);
        chk("rst_alu_a", 32'(alu_a), 0);
        chk("rst_alu_b", 32'(alu_b), 0);
        chk("rst_res_valid", 32'(res_valid), 0);
        chk("rst_res_data", 32'(res_data), 0);
        chk("rst_res_tag", 32'(res_tag), 0);
        chk("rst_res_err", 32'(res_err), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err_cnt", 32'(err_cnt), 0);
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
    endtask

    task automatic drain(int max);
        int n = 0;
        while ((src_q.size() || fifo_q.size() || inflight || cmd_valid || push_pend || hs_pend) && n < max) begin
            step();
            n++;
        end
        chk("drain_in_budget", 32'(n < max), 1);
    endtask

    initial begin
        int n;
        do_reset();
        ready_pct = 100;
        src_q.push_back(mk(3'd0, 8'd2, 8'd5, 2));
        drain(100);
        chk("first_tag_done", 32'(res_tag), 1);
        for (int i = 0; i < 6; i++) src_q.push_back(mk(3'(i), 8'd2, 8'd5, 1));
        drain(200);
        chk("burst_filled_fifo", 32'(saw_full), 1);
        chk("burst_tags", 32'(res_tag), 7);
        ready_pct = 8;
        for (int i = 0; i < 8; i++) src_q.push_back(mk(3'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(4, 1))));
        drain(2000);
        ready_pct = 100;
        n = errs;
        src_q.push_back(mk(3'd3, 8'h5a, 8'h0f, NEVER));
        src_q.push_back(mk(3'd0, 8'd1, 8'd1, 1));
        drain(400);
        chk("timeout_err_cnt", 32'(err_cnt), 32'(n + 1));
        for (int i = 0; i < 4; i++) src_q.push_back(mk(3'd2, 8'(i), 8'd3, NEVER));
        n = 0;
        while (!(inflight && fifo_q.size() == 3) && n < 100) begin step(); n++; end
        chk("queued_three", 32'(n < 100), 1);
        repeat (5) step();
        do_reset();
        rem = 2;
        repeat (10) step();
        chk("post_rst_no_result", 32'(res_valid), 0);
        chk("post_rst_idle", 32'(busy), 0);
        for (int i = 0; i < 17; i++) src_q.push_back(mk(3'($urandom), 8'($urandom), 8'($urandom), 1));
        drain(400);
        chk("tag_wrapped", 32'(res_tag), 1);
        ready_pct = 70;
        for (int i = 0; i < 40; i++) src_q.push_back(mk(3'($urandom), 8'($urandom), 8'($urandom), rnd_lat()));
        drain(8000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_bad);
        $fatal(1);
    end
endmodule
